// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: Moore control sequencer for one register-file/ALU command at a time.
// Latency from the edge that samples s to w=1: MOVI 2, MOVR 4, CMP 4, ALU 5 clocks.
// Backpressure: w=1 only in WAIT; s is ignored while a command is in flight.
// Optional build macro ALU_SEQ_PERF_EN adds a 16-bit completed-command counter (cmd_count).
module alu_cmd_sequencer #(
    parameter int RN_W  = 3,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [1:0]       cmd,
    input  logic [1:0]       op,
    input  logic [RN_W-1:0]  rn,
    input  logic [RN_W-1:0]  rd,
    input  logic [RN_W-1:0]  rm,
    input  logic [IMM_W-1:0] imm,
    output logic             w,
    output logic [RN_W-1:0]  readnum,
    output logic [RN_W-1:0]  writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             vsel,
    output logic [1:0]       aluop,
`ifdef ALU_SEQ_PERF_EN
    output logic [15:0]      cmd_count,
`endif
    output logic [IMM_W-1:0] imm_q
);

    localparam logic [1:0] CMD_MOVI = 2'b00;
    localparam logic [1:0] CMD_MOVR = 2'b01;
    localparam logic [1:0] CMD_ALU  = 2'b10;
    localparam logic [1:0] CMD_CMP  = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_LOADA = 3'd1,
        ST_LOADB = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4,
        ST_WRIMM = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [1:0]        op_q, op_d;
    logic [RN_W-1:0]   rn_q, rn_d;
    logic [RN_W-1:0]   rd_q, rd_d;
    logic [RN_W-1:0]   rm_q, rm_d;
    logic [IMM_W-1:0]  imm_d;

    // State and captured-command registers; reset drops any in-flight command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT;
            cmd_q   <= CMD_MOVI;
            op_q    <= OP_ADD;
            rn_q    <= '0;
            rd_q    <= '0;
            rm_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op_q    <= op_d;
            rn_q    <= rn_d;
            rd_q    <= rd_d;
            rm_q    <= rm_d;
            imm_q   <= imm_d;
        end
    end

    // Next state and command capture; fields are only reloaded when a command starts.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op_d    = op_q;
        rn_d    = rn_q;
        rd_d    = rd_q;
        rm_d    = rm_q;
        imm_d   = imm_q;
        case (state_q)
            ST_WAIT: begin
                if (s) begin
                    cmd_d = cmd;
                    op_d  = op;
                    rn_d  = rn;
                    rd_d  = rd;
                    rm_d  = rm;
                    imm_d = imm;
                    case (cmd)
                        CMD_MOVI: state_d = ST_WRIMM;
                        CMD_MOVR: state_d = ST_LOADB;
                        default:  state_d = ST_LOADA;
                    endcase
                end
            end
            ST_LOADA: state_d = ST_LOADB;
            ST_LOADB: state_d = ST_EXEC;
            // A compare only updates status flags, so it skips write-back.
            ST_EXEC:  state_d = (cmd_q == CMD_CMP) ? ST_WAIT : ST_WRITE;
            ST_WRITE: state_d = ST_WAIT;
            ST_WRIMM: state_d = ST_WAIT;
            default:  state_d = ST_WAIT;
        endcase
    end

    // Moore output decode: every control line is a function of state and captured fields.
    always_comb begin
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = 1'b0;
        aluop    = OP_ADD;
        case (state_q)
            ST_WAIT: begin
                w = 1'b1;
            end
            ST_LOADA: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            ST_LOADB: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            ST_EXEC: begin
                loadc = 1'b1;
                case (cmd_q)
                    CMD_ALU: begin
                        aluop = op_q;
                        loads = 1'b1;
                    end
                    CMD_CMP: begin
                        aluop = OP_SUB;
                        loads = 1'b1;
                    end
                    default: begin
                        // MOVR passes B through as 0 + B without touching flags.
                        aluop = OP_ADD;
                        asel  = 1'b1;
                    end
                endcase
            end
            ST_WRITE: begin
                writenum = rd_q;
                write    = 1'b1;
            end
            ST_WRIMM: begin
                writenum = rd_q;
                write    = 1'b1;
                vsel     = 1'b1;
            end
            default: begin
                w = 1'b1;
            end
        endcase
    end

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] cmd_count_q, cmd_count_d;
    logic        cmd_done;

    // A command completes on the last step before returning to WAIT.
    always_comb begin
        cmd_done    = (state_q == ST_WRITE) || (state_q == ST_WRIMM) ||
                      ((state_q == ST_EXEC) && (cmd_q == CMD_CMP));
        cmd_count_d = cmd_count_q;
        if (cmd_done) begin
            cmd_count_d = cmd_count_q + 16'd1;
        end
    end

    // Completed-command counter, free-running with natural wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_count_q <= '0;
        end else begin
            cmd_count_q <= cmd_count_d;
        end
    end

    assign cmd_count = cmd_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: per-cycle control vectors are queued when a
// command is issued and compared one per clock as the sequencer steps through it.
// Build with ALU_SEQ_PERF_EN to also check the completed-command counter.
module tb_alu_cmd_sequencer;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       vsel;
        logic [1:0] aluop;
    } ctl_t;

    logic        clk;
    logic        reset;
    logic        s;
    logic [1:0]  cmd;
    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    logic [15:0] imm;
    logic        w;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, vsel;
    logic [1:0]  aluop;
    logic [15:0] imm_q;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] cmd_count;
`endif

    int   tests;
    int   fails;
    int   exp_count;
    ctl_t exp_q[$];

    alu_cmd_sequencer #(.RN_W(3), .IMM_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .cmd      (cmd),
        .op       (op),
        .rn       (rn),
        .rd       (rd),
        .rm       (rm),
        .imm      (imm),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .vsel     (vsel),
        .aluop    (aluop),
`ifdef ALU_SEQ_PERF_EN
        .cmd_count(cmd_count),
`endif
        .imm_q    (imm_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t c_idle();
        ctl_t c;
        c   = '0;
        c.w = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_loada(logic [2:0] r);
        ctl_t c;
        c         = '0;
        c.readnum = r;
        c.loada   = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_loadb(logic [2:0] r);
        ctl_t c;
        c         = '0;
        c.readnum = r;
        c.loadb   = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_exec(logic [1:0] o, logic as, logic ls);
        ctl_t c;
        c       = '0;
        c.loadc = 1'b1;
        c.aluop = o;
        c.asel  = as;
        c.loads = ls;
        return c;
    endfunction

    function automatic ctl_t c_write(logic [2:0] r, logic vs);
        ctl_t c;
        c          = '0;
        c.writenum = r;
        c.write    = 1'b1;
        c.vsel     = vs;
        return c;
    endfunction

    function automatic ctl_t observe();
        return {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel, aluop};
    endfunction

    task automatic check_ctl(input string tag, input ctl_t exp);
        ctl_t obs;
        obs = observe();
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed ctl=%h expected ctl=%h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected control sequence for one command, ending in the idle WAIT cycle.
    task automatic push_cmd(input logic [1:0] c, input logic [1:0] o,
                            input logic [2:0] n, input logic [2:0] d, input logic [2:0] m);
        case (c)
            2'b00: begin
                exp_q.push_back(c_write(d, 1'b1));
            end
            2'b01: begin
                exp_q.push_back(c_loadb(m));
                exp_q.push_back(c_exec(2'b00, 1'b1, 1'b0));
                exp_q.push_back(c_write(d, 1'b0));
            end
            2'b10: begin
                exp_q.push_back(c_loada(n));
                exp_q.push_back(c_loadb(m));
                exp_q.push_back(c_exec(o, 1'b0, 1'b1));
                exp_q.push_back(c_write(d, 1'b0));
            end
            default: begin
                exp_q.push_back(c_loada(n));
                exp_q.push_back(c_loadb(m));
                exp_q.push_back(c_exec(2'b01, 1'b0, 1'b1));
            end
        endcase
        exp_q.push_back(c_idle());
    endtask

    // Called #1 after the edge that produced the current state; compares one
    // queued vector per clock. With pulse set, s is raised while busy.
    task automatic drain(input string tag, input logic pulse);
        ctl_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_ctl(tag, e);
            if (exp_q.size() > 0) begin
                s   = pulse;
                cmd = 2'b00;
                @(posedge clk);
                #1;
                s = 1'b0;
            end
        end
    endtask

    // Drives a command while in WAIT (caller is #1 after an edge) and checks it to completion.
    task automatic run_cmd(input string tag, input logic [1:0] c, input logic [1:0] o,
                           input logic [2:0] n, input logic [2:0] d, input logic [2:0] m,
                           input logic [15:0] im, input logic pulse);
        cmd = c; op = o; rn = n; rd = d; rm = m; imm = im;
        s   = 1'b1;
        push_cmd(c, o, n, d, m);
        @(posedge clk);
        #1;
        s = 1'b0;
        drain(tag, pulse);
        exp_count++;
    endtask

    initial begin
        tests = 0; fails = 0; exp_count = 0;
        reset = 1'b1; s = 1'b0; cmd = 2'b00; op = 2'b00;
        rn = '0; rd = '0; rm = '0; imm = '0;

        repeat (2) @(posedge clk);
        #1;
        check_ctl("reset_ctl", c_idle());
        check_val("reset_imm_q", imm_q, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_ctl("idle_after_reset", c_idle());

        run_cmd("movi_r3", 2'b00, 2'b00, 3'd0, 3'd3, 3'd0, 16'h0042, 1'b0);
        check_val("movi_imm_q", imm_q, 16'h0042);

        run_cmd("alu_sub", 2'b10, 2'b01, 3'd1, 3'd4, 3'd2, 16'h1111, 1'b0);
        // Back-to-back: started on the first WAIT cycle after the ALU command.
        run_cmd("cmp_b2b", 2'b11, 2'b00, 3'd5, 3'd6, 3'd5, 16'h2222, 1'b0);
        check_val("imm_q_tracks_capture", imm_q, 16'h2222);

        run_cmd("movr_busy_s", 2'b01, 2'b10, 3'd3, 3'd0, 3'd7, 16'h3333, 1'b1);
        @(posedge clk);
        #1;
        check_ctl("movr_stays_idle", c_idle());

        run_cmd("alu_add", 2'b10, 2'b00, 3'd6, 3'd7, 3'd3, 16'h0000, 1'b0);
        run_cmd("alu_and", 2'b10, 2'b10, 3'd2, 3'd1, 3'd4, 16'h0000, 1'b1);
        run_cmd("alu_notb", 2'b10, 2'b11, 3'd7, 3'd5, 3'd0, 16'h0000, 1'b0);
        run_cmd("cmp_op_ignored", 2'b11, 2'b10, 3'd2, 3'd7, 3'd6, 16'h0000, 1'b1);
        run_cmd("movi_r7_ffff", 2'b00, 2'b11, 3'd5, 3'd7, 3'd6, 16'hFFFF, 1'b0);
        check_val("movi_imm_q_ffff", imm_q, 16'hFFFF);
`ifdef ALU_SEQ_PERF_EN
        check_val("cmd_count_run", cmd_count, exp_count[15:0]);
`endif

        // Reset during EXEC of an ALU command.
        cmd = 2'b10; op = 2'b01; rn = 3'd1; rd = 3'd2; rm = 3'd3; imm = 16'hABCD;
        s   = 1'b1;
        push_cmd(2'b10, 2'b01, 3'd1, 3'd2, 3'd3);
        @(posedge clk);
        #1;
        s = 1'b0;
        check_ctl("rst_mid_loada", exp_q.pop_front());
        @(posedge clk);
        #1;
        check_ctl("rst_mid_loadb", exp_q.pop_front());
        @(posedge clk);
        #1;
        check_ctl("rst_mid_exec", exp_q.pop_front());
        exp_q.delete();
        reset = 1'b1;
        #1;
        check_ctl("rst_mid_now_idle", c_idle());
        check_val("rst_mid_imm_q", imm_q, 16'h0000);
        exp_count = 0;
        @(posedge clk);
        #1;
        check_ctl("rst_held_idle", c_idle());
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_ctl("rst_release_no_write", c_idle());
`ifdef ALU_SEQ_PERF_EN
        check_val("cmd_count_reset", cmd_count, 16'h0000);
`endif

        run_cmd("movi_after_rst", 2'b00, 2'b00, 3'd0, 3'd1, 3'd0, 16'h0BEE, 1'b0);
        check_val("movi_after_rst_imm", imm_q, 16'h0BEE);
        run_cmd("cmp_after_rst", 2'b11, 2'b00, 3'd4, 3'd0, 3'd3, 16'h0000, 1'b0);
`ifdef ALU_SEQ_PERF_EN
        check_val("cmd_count_end", cmd_count, exp_count[15:0]);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
